branch_rs: RTL and testbench
============================

// Module: branch_rs
// PURPOSE
//  Branch reservation station: the issuing end of the branch unit's issue interface. Buffers dispatched
//  JALR and conditional branch ops, wakes sources from the completion broadcast, and issues the oldest ready
//  entry (one per cycle) with PRF read addresses. Sits between dispatch/rename and branch_unit.
// PARAMETERS
//  DEPTH       4  number of entries (>=2)
//  NUM_WAKEUP  2  wakeup broadcast ports (ALU, branch/LSU writeback)
// PORTS
//  clk              in   1                   clock, rising edge
//  rst_n            in   1                   async active-low reset
//  flush            in   1                   mispredict flush (sync, from branch unit mispredict path)
//  dispatch_valid   in   1                   dispatch request
//  dispatch_entry   in   rs_entry_t          renamed op; rs1_ready/rs2_ready valid as of dispatch
//  dispatch_ready   out  1                   space available
//  wakeup_valid     in   NUM_WAKEUP          wakeup broadcast valid
//  wakeup_prd       in   NUM_WAKEUP*PHYS_REG_BITS  physical dest being written
//  fu_ready         in   1                   branch unit ready
//  issue_en         out  1                   entry issued this cycle
//  issue_entry      out  rs_entry_t          issued entry, fields unmodified except ready bits (=1)
//  issue_prs1       out  PHYS_REG_BITS       PRF read addr rs1 (comb, same cycle as issue_en)
//  issue_prs2       out  PHYS_REG_BITS       PRF read addr rs2
//  occupancy        out  $clog2(DEPTH+1)     valid entry count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all entries invalid, occupancy=0, dispatch_ready=1, issue_en=0, issue_entry='0.
//  - Storage is an age-ordered compacting queue: slot 0 oldest; new entry appended at slot occupancy.
//  - dispatch_ready = (occupancy < DEPTH), from registered state only; same-cycle issue does NOT free space.
//  - Accept when dispatch_valid && dispatch_ready && !flush; captured next edge.
//  - Wakeup: any wakeup_valid[i] with wakeup_prd[i]==prsN sets rsN_ready at next edge; applies to stored
//    entries AND to the entry being dispatched the same cycle (dispatch bypass). Ops with no rs2 (JALR) are
//    dispatched with rs2_ready=1. prd 0 never sent as wakeup; no special casing.
//  - Select: combinational, lowest valid slot with rs1_ready && rs2_ready, using registered ready bits only
//    (a wakeup in cycle N makes an entry eligible in cycle N+1, never N).
//  - issue_en = fu_ready && found && !flush; issue_entry/issue_prs* driven from selected slot
//    (don't-care data when issue_en=0). Zero-cycle issue: branch_unit latches on same edge.
//  - On issue, selected slot removed; younger slots shift down one; append position accounts for it.
//    Issue + dispatch same cycle: net occupancy unchanged, new entry lands at occupancy-1.
//  - flush: all entries invalid next edge, occupancy=0; dispatch and issue suppressed that cycle.
//  - No ordering with other RS; ROB tag carried through untouched. No wrap-around (compacting, not circular).
//  - Assert (sim): no dispatch when !dispatch_ready; occupancy never > DEPTH.
// STRUCTURE
//  - ooo_types owns rs_entry_t (pc, immediate, alu_op, prs1, prs2, rs1_ready, rs2_ready, prd, rob_tag,
//    reg_write), PHYS_REG_BITS, ROB_BITS; add BRANCH_RS_DEPTH default there.
//  - One sub-module: rs_oldest_select (comb priority pick: ready vector -> found, one-hot, index).
//  - Wakeup compare, shift/insert and occupancy counter inline in branch_rs.
// TESTING
//  1. Reset mid-operation: 3 entries held, pull rst_n low asynchronously -> occupancy=0, issue_en=0
//     immediately, dispatch_ready=1.
//  2. Dispatch BEQ prs1=5,prs2=6 not ready; wakeup prd=5 cycle 2, prd=6 cycle 4 -> issue_en first in cycle 5,
//     issue_prs1=5, issue_prs2=6, rob_tag preserved.
//  3. Fill 4 ready entries (rob_tag 1..4), fu_ready=1 -> issue order 1,2,3,4 one per cycle; dispatch_ready=0
//     while occupancy=4, 1 again after first issue edge.
//  4. Dispatch-cycle bypass: dispatch JALR prs1=9 not ready with wakeup_prd[1]=9 same cycle -> issues next cycle.
//  5. Age vs readiness: tag 7 (not ready) older than tag 8 (ready) -> tag 8 issues first; tag 7 after wakeup.
//  6. Flush with occupancy=3 plus concurrent dispatch_valid and fu_ready -> no issue that cycle, occupancy=0
//     next cycle, dispatched op dropped.

Source files
------------

// File: rtl/branch_rs_pkg.sv
// Shared out-of-order types for the branch reservation station: entry layout, register/tag widths
// and the default depth.
package branch_rs_pkg;

    localparam int unsigned PHYS_REG_BITS   = 6;
    localparam int unsigned ROB_BITS        = 5;
    localparam int unsigned BRANCH_RS_DEPTH = 4;

    typedef enum logic [2:0] {
        BR_BEQ,
        BR_BNE,
        BR_BLT,
        BR_BGE,
        BR_BLTU,
        BR_BGEU,
        BR_JALR
    } br_op_t;

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              immediate;
        br_op_t                   alu_op;
        logic [PHYS_REG_BITS-1:0] prs1;
        logic [PHYS_REG_BITS-1:0] prs2;
        logic                     rs1_ready;
        logic                     rs2_ready;
        logic [PHYS_REG_BITS-1:0] prd;
        logic [ROB_BITS-1:0]      rob_tag;
        logic                     reg_write;
    } rs_entry_t;

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch / wakeup / issue bundle of the branch reservation station.
// master = dispatch/rename + branch unit side, slave = the reservation station.
interface branch_rs_if #(
    parameter int unsigned DEPTH      = branch_rs_pkg::BRANCH_RS_DEPTH,
    parameter int unsigned NUM_WAKEUP = 2
) ();
    import branch_rs_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                                flush;
    logic                                dispatch_valid;
    rs_entry_t                           dispatch_entry;
    logic                                dispatch_ready;
    logic [NUM_WAKEUP-1:0]               wakeup_valid;
    logic [NUM_WAKEUP*PHYS_REG_BITS-1:0] wakeup_prd;
    logic                                fu_ready;
    logic                                issue_en;
    rs_entry_t                           issue_entry;
    logic [PHYS_REG_BITS-1:0]            issue_prs1;
    logic [PHYS_REG_BITS-1:0]            issue_prs2;
    logic [CntW-1:0]                     occupancy;

    modport master (
        output flush, dispatch_valid, dispatch_entry, wakeup_valid, wakeup_prd, fu_ready,
        input  dispatch_ready, issue_en, issue_entry, issue_prs1, issue_prs2, occupancy
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_entry, wakeup_valid, wakeup_prd, fu_ready,
        output dispatch_ready, issue_en, issue_entry, issue_prs1, issue_prs2, occupancy
    );

endinterface

// File: rtl/branch_rs_oldest_select.sv
// Priority pick of the lowest-numbered (oldest) ready slot: found flag, one-hot and binary index.
module rs_oldest_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         i_ready,
    output logic                     o_found,
    output logic [DEPTH-1:0]         o_onehot,
    output logic [$clog2(DEPTH)-1:0] o_index
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    // Scan youngest to oldest so the oldest ready slot is the last writer.
    always_comb begin
        o_found  = 1'b0;
        o_onehot = '0;
        o_index  = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_found     = 1'b1;
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_index     = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: age-ordered compacting queue with wakeup snooping (including the
// entry being dispatched) and oldest-ready, zero-cycle issue to the branch unit.
module branch_rs import branch_rs_pkg::*; #(
    parameter int unsigned DEPTH      = BRANCH_RS_DEPTH,
    parameter int unsigned NUM_WAKEUP = 2
) (
    input logic        clk,
    input logic        rst_n,
    branch_rs_if.slave rs
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    rs_entry_t        r_entries [DEPTH];
    logic [CntW-1:0]  r_count;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_sel_onehot;
    logic             w_found;
    logic [IdxW-1:0]  w_sel_idx;
    logic             w_issue;
    logic             w_accept;
    rs_entry_t        w_sel_entry;
    rs_entry_t        w_new;
    rs_entry_t        w_woken [DEPTH];
    rs_entry_t        w_shift [DEPTH];
    rs_entry_t        w_next  [DEPTH];
    logic [CntW-1:0]  w_cnt_after_issue;
    logic [CntW-1:0]  w_count_d;

    function automatic logic woken(input logic [PHYS_REG_BITS-1:0]            prs,
                                   input logic [NUM_WAKEUP-1:0]               vld,
                                   input logic [NUM_WAKEUP*PHYS_REG_BITS-1:0] prd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_WAKEUP); i++) begin
            hit |= vld[i] && (prd[i*PHYS_REG_BITS +: PHYS_REG_BITS] == prs);
        end
        return hit;
    endfunction

    // Eligibility uses registered ready bits only; this cycle's wakeups count from next cycle.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_ready[i] = (CntW'(i) < r_count) && r_entries[i].rs1_ready
                         && r_entries[i].rs2_ready;
        end
    end

    rs_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .i_ready  (w_ready),
        .o_found  (w_found),
        .o_onehot (w_sel_onehot),
        .o_index  (w_sel_idx)
    );

    always_comb begin
        w_sel_entry = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_sel_onehot[i]) w_sel_entry = r_entries[i];
        end
    end

    assign rs.dispatch_ready = (r_count < CntW'(DEPTH));
    assign w_issue           = rs.fu_ready && w_found && !rs.flush;
    assign w_accept          = rs.dispatch_valid && rs.dispatch_ready && !rs.flush;

    assign rs.issue_en    = w_issue;
    assign rs.issue_entry = w_issue ? w_sel_entry : '0;
    assign rs.issue_prs1  = rs.issue_entry.prs1;
    assign rs.issue_prs2  = rs.issue_entry.prs2;
    assign rs.occupancy   = r_count;

    always_comb begin
        w_new           = rs.dispatch_entry;
        w_new.rs1_ready = rs.dispatch_entry.rs1_ready
                          | woken(rs.dispatch_entry.prs1, rs.wakeup_valid, rs.wakeup_prd);
        w_new.rs2_ready = rs.dispatch_entry.rs2_ready
                          | woken(rs.dispatch_entry.prs2, rs.wakeup_valid, rs.wakeup_prd);

        for (int i = 0; i < int'(DEPTH); i++) begin
            w_woken[i]           = r_entries[i];
            w_woken[i].rs1_ready = r_entries[i].rs1_ready
                                   | woken(r_entries[i].prs1, rs.wakeup_valid, rs.wakeup_prd);
            w_woken[i].rs2_ready = r_entries[i].rs2_ready
                                   | woken(r_entries[i].prs2, rs.wakeup_valid, rs.wakeup_prd);
        end

        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            w_shift[i] = w_woken[i+1];
        end
        w_shift[DEPTH-1] = '0;

        // Issue compacts first, so a same-cycle dispatch lands in the freed tail slot.
        w_cnt_after_issue = r_count - CntW'(w_issue);
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_next[i] = (w_issue && (IdxW'(i) >= w_sel_idx)) ? w_shift[i] : w_woken[i];
            if (w_accept && (CntW'(i) == w_cnt_after_issue)) w_next[i] = w_new;
        end

        w_count_d = rs.flush ? '0 : (w_cnt_after_issue + CntW'(w_accept));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= '0;
        end else begin
            r_count <= w_count_d;
            for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= w_next[i];
        end
    end

    a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(rs.dispatch_valid && !rs.dispatch_ready));
    a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CntW'(DEPTH));

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: expected issues are queued as ops are dispatched and popped
// in order whenever the station issues.
module tb_branch_rs;
    import branch_rs_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NW    = 2;
    localparam int unsigned PRB   = PHYS_REG_BITS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_rs_if #(.DEPTH(DEPTH), .NUM_WAKEUP(NW)) bus ();

    branch_rs #(
        .DEPTH      (DEPTH),
        .NUM_WAKEUP (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus)
    );

    int        checks = 0;
    int        errors = 0;
    rs_entry_t sb[$];
    rs_entry_t exp_e;

    function automatic rs_entry_t mk(input int tag, input int p1, input int p2,
                                     input logic r1, input logic r2, input br_op_t op);
        rs_entry_t e;
        e           = '0;
        e.pc        = 32'h0000_1000 + 32'(tag * 4);
        e.immediate = 32'(tag * 16 + 3);
        e.alu_op    = op;
        e.prs1      = PRB'(p1);
        e.prs2      = PRB'(p2);
        e.rs1_ready = r1;
        e.rs2_ready = r2;
        e.prd       = PRB'(tag + 32);
        e.rob_tag   = ROB_BITS'(tag);
        e.reg_write = (op == BR_JALR);
        return e;
    endfunction

    function automatic rs_entry_t as_issued(input rs_entry_t e);
        rs_entry_t r;
        r           = e;
        r.rs1_ready = 1'b1;
        r.rs2_ready = 1'b1;
        return r;
    endfunction

    task automatic idle();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_entry = '0;
        bus.wakeup_valid   = '0;
        bus.wakeup_prd     = '0;
        bus.fu_ready       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        for (int t = 1; t <= 3; t++) begin
            bus.dispatch_valid = 1'b1;
            bus.dispatch_entry = mk(40 + t, t, t + 1, 1'b1, 1'b1, BR_BEQ);
            tick();
        end
        bus.dispatch_valid = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 3'd3) begin
            errors++; $display("FAIL reset_pre_occ got %0d want 3", bus.occupancy);
        end
        bus.fu_ready = 1'b1;
        #1;
        checks++;
        if (bus.issue_en !== 1'b1) begin
            errors++; $display("FAIL reset_pre_issue got %0b want 1", bus.issue_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL reset_occ got %0d want 0", bus.occupancy);
        end
        checks++;
        if (bus.issue_en !== 1'b0) begin
            errors++; $display("FAIL reset_issue_en got %0b want 0", bus.issue_en);
        end
        checks++;
        if (bus.dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_dispatch_ready got %0b want 1", bus.dispatch_ready);
        end
        checks++;
        if (bus.issue_entry !== rs_entry_t'('0)) begin
            errors++; $display("FAIL reset_issue_entry got %h want 0", bus.issue_entry);
        end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wakeup_latency();
        rs_entry_t e;
        idle();
        bus.fu_ready = 1'b1;
        e = mk(3, 5, 6, 1'b0, 1'b0, BR_BEQ);
        sb.push_back(as_issued(e));
        for (int c = 1; c <= 5; c++) begin
            bus.dispatch_valid = (c == 1);
            bus.dispatch_entry = e;
            bus.wakeup_valid   = '0;
            bus.wakeup_prd     = '0;
            if (c == 2) begin
                bus.wakeup_valid[0]       = 1'b1;
                bus.wakeup_prd[0 +: PRB]  = PRB'(5);
            end
            if (c == 4) begin
                bus.wakeup_valid[1]       = 1'b1;
                bus.wakeup_prd[PRB +: PRB] = PRB'(6);
            end
            #1;
            checks++;
            if (bus.issue_en !== (c == 5)) begin
                errors++; $display("FAIL wake_issue_en cycle %0d got %0b want %0b",
                                   c, bus.issue_en, (c == 5));
            end
            if (bus.issue_en === 1'b1 && sb.size() > 0) begin
                exp_e = sb.pop_front();
                checks++;
                if (bus.issue_entry !== exp_e || bus.issue_prs1 !== exp_e.prs1
                    || bus.issue_prs2 !== exp_e.prs2) begin
                    errors++; $display("FAIL wake_issue got tag %0d prs %0d/%0d want tag %0d prs %0d/%0d",
                        bus.issue_entry.rob_tag, bus.issue_prs1, bus.issue_prs2,
                        exp_e.rob_tag, exp_e.prs1, exp_e.prs2);
                end
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL wake_drain_occ got %0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_fill_drain();
        idle();
        for (int t = 1; t <= 4; t++) begin
            bus.dispatch_valid = 1'b1;
            bus.dispatch_entry = mk(t, t + 16, t + 20, 1'b1, 1'b1, BR_BNE);
            sb.push_back(as_issued(bus.dispatch_entry));
            #1;
            checks++;
            if (bus.dispatch_ready !== 1'b1) begin
                errors++; $display("FAIL fill_ready slot %0d got %0b want 1", t, bus.dispatch_ready);
            end
            tick();
        end
        bus.dispatch_valid = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 3'd4 || bus.dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got occ %0d ready %0b want occ 4 ready 0",
                               bus.occupancy, bus.dispatch_ready);
        end
        bus.fu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.dispatch_ready !== (k != 0)) begin
                errors++; $display("FAIL drain_ready step %0d got %0b want %0b",
                                   k, bus.dispatch_ready, (k != 0));
            end
            checks++;
            if (bus.issue_en !== 1'b1) begin
                errors++; $display("FAIL drain_issue_en step %0d got %0b want 1", k, bus.issue_en);
            end else if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                checks++;
                if (bus.issue_entry !== exp_e) begin
                    errors++; $display("FAIL drain_order step %0d got tag %0d want tag %0d",
                                       k, bus.issue_entry.rob_tag, exp_e.rob_tag);
                end
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL drain_occ got %0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.fu_ready                = 1'b1;
        bus.dispatch_valid          = 1'b1;
        bus.dispatch_entry          = mk(9, 9, 0, 1'b0, 1'b1, BR_JALR);
        bus.wakeup_valid[1]         = 1'b1;
        bus.wakeup_prd[PRB +: PRB]  = PRB'(9);
        sb.push_back(as_issued(bus.dispatch_entry));
        #1;
        checks++;
        if (bus.issue_en !== 1'b0) begin
            errors++; $display("FAIL bypass_same_cycle got %0b want 0", bus.issue_en);
        end
        tick();
        idle();
        bus.fu_ready = 1'b1;
        #1;
        checks++;
        if (bus.issue_en !== 1'b1) begin
            errors++; $display("FAIL bypass_issue_en got %0b want 1", bus.issue_en);
        end else if (sb.size() > 0) begin
            exp_e = sb.pop_front();
            checks++;
            if (bus.issue_entry !== exp_e || bus.issue_prs1 !== exp_e.prs1) begin
                errors++; $display("FAIL bypass_issue got tag %0d prs1 %0d want tag %0d prs1 %0d",
                    bus.issue_entry.rob_tag, bus.issue_prs1, exp_e.rob_tag, exp_e.prs1);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_age_vs_ready();
        rs_entry_t old_e;
        rs_entry_t young_e;
        idle();
        old_e   = mk(7, 10, 11, 1'b0, 1'b1, BR_BLT);
        young_e = mk(8, 12, 13, 1'b1, 1'b1, BR_BGE);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = old_e;
        tick();
        bus.dispatch_entry = young_e;
        tick();
        sb.push_back(as_issued(young_e));
        sb.push_back(as_issued(old_e));
        idle();
        bus.fu_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.wakeup_valid = '0;
            bus.wakeup_prd   = '0;
            if (c == 1) begin
                bus.wakeup_valid[0]      = 1'b1;
                bus.wakeup_prd[0 +: PRB] = PRB'(10);
            end
            #1;
            checks++;
            if (bus.issue_en !== (c != 1)) begin
                errors++; $display("FAIL age_issue_en cycle %0d got %0b want %0b",
                                   c, bus.issue_en, (c != 1));
            end
            if (bus.issue_en === 1'b1 && sb.size() > 0) begin
                exp_e = sb.pop_front();
                checks++;
                if (bus.issue_entry !== exp_e) begin
                    errors++; $display("FAIL age_order cycle %0d got tag %0d want tag %0d",
                                       c, bus.issue_entry.rob_tag, exp_e.rob_tag);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int t = 11; t <= 13; t++) begin
            bus.dispatch_valid = 1'b1;
            bus.dispatch_entry = mk(t, t, t + 1, 1'b1, 1'b1, BR_BLTU);
            tick();
        end
        bus.flush          = 1'b1;
        bus.dispatch_entry = mk(14, 14, 15, 1'b1, 1'b1, BR_BGEU);
        bus.fu_ready       = 1'b1;
        #1;
        checks++;
        if (bus.issue_en !== 1'b0) begin
            errors++; $display("FAIL flush_issue_en got %0b want 0", bus.issue_en);
        end
        tick();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        #1;
        checks++;
        if (bus.occupancy !== 3'd0 || bus.issue_en !== 1'b0) begin
            errors++; $display("FAIL flush_after got occ %0d issue_en %0b want occ 0 issue_en 0",
                               bus.occupancy, bus.issue_en);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int t = 20; t <= 21; t++) begin
            bus.dispatch_valid = 1'b1;
            bus.dispatch_entry = mk(t, t - 10, t - 5, 1'b1, 1'b1, BR_BEQ);
            sb.push_back(as_issued(bus.dispatch_entry));
            tick();
        end
        bus.fu_ready       = 1'b1;
        bus.dispatch_entry = mk(22, 3, 4, 1'b1, 1'b1, BR_BNE);
        sb.push_back(as_issued(bus.dispatch_entry));
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.issue_en !== 1'b1) begin
                errors++; $display("FAIL b2b_issue_en cycle %0d got %0b want 1", c, bus.issue_en);
            end else if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                checks++;
                if (bus.issue_entry !== exp_e) begin
                    errors++; $display("FAIL b2b_order cycle %0d got tag %0d want tag %0d",
                                       c, bus.issue_entry.rob_tag, exp_e.rob_tag);
                end
            end
            tick();
            bus.dispatch_valid = 1'b0;
            if (c == 0) begin
                #1;
                checks++;
                if (bus.occupancy !== 3'd2) begin
                    errors++; $display("FAIL b2b_occ got %0d want 2", bus.occupancy);
                end
            end
        end
        idle();
        #1;
        checks++;
        if (bus.occupancy !== 3'd0) begin
            errors++; $display("FAIL b2b_drain_occ got %0d want 0", bus.occupancy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_reset();
        test_wakeup_latency();
        test_fill_drain();
        test_bypass();
        test_age_vs_ready();
        test_flush();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
